fpro_key_ctrl: RTL and testbench
================================

// Module: fpro_key_ctrl
// PURPOSE
//  Avalon-MM slave controller for the board push-keys. It replaces the raw key PIO with
//  synchronised, debounced key levels, per-key press (falling-edge) capture and a maskable IRQ.
//  Sits on the Nios/FPRO system bus beside the other PIO slaves; in_port wires to the KEY pins
//  (active-low, released = 1).
// PARAMETERS
//  N_KEYS      2       number of keys (1..32)
//  DEB_CYCLES  500000  cycles a synchronised level must hold before acceptance (10 ms @ 50 MHz), >=2
//  CNT_W       19      debounce counter width; must satisfy 2**CNT_W >= DEB_CYCLES
// PORTS
//  clk         in   1       system clock
//  reset_n     in   1       asynchronous active-low reset
//  chipselect  in   1       slave select
//  address     in   2       register index
//  write_n     in   1       active-low write strobe (qualified by chipselect)
//  writedata   in   32      write data
//  readdata    out  32      registered read data
//  in_port     in   N_KEYS  raw asynchronous key pins
//  irq         out  1       level interrupt
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low (clk, reset_n).
//   Reset values: sync FFs = all 1, debounced = all 1, counters = 0, mask = 0, edge = 0,
//   irq = 0, readdata = 0.
//  Register map (bits above N_KEYS read 0):
//   0 DATA      RO    debounced levels
//   1 IRQ_MASK  RW    bit=1 enables that key's IRQ
//   2 EDGE_CAP  R/W1C captured presses; writing 1 clears the bit, writing 0 leaves it unchanged
//   3 RAW       RO    synchroniser output (diagnostic)
//  Read: readdata <= mux(address), zero-extended, every clock regardless of chipselect.
//   1-cycle latency. Reads have no side effects.
//  Write: takes effect on the clock edge where chipselect=1 and write_n=0.
//   Writes to addresses 0 and 3 are ignored.
//  Synchroniser: 2-FF per key, with no reset dependence on in_port.
//  Debounce FSM per key, states STABLE and COUNT:
//   STABLE: sync != deb -> COUNT, cnt <= 1. Otherwise cnt stays 0.
//   COUNT: sync == deb -> STABLE, cnt <= 0 (bounce rejected).
//   COUNT: cnt == DEB_CYCLES-1 -> deb <= sync, cnt <= 0, STABLE.
//   COUNT: otherwise cnt <= cnt+1.
//   Latency: a clean level change on in_port appears in deb exactly DEB_CYCLES+2 clocks later.
//  Edge capture: deb 1->0 sets the EDGE_CAP bit on the same edge deb updates.
//   Release (0->1) captures nothing.
//   Set and W1C on the same bit in the same cycle: set wins.
//  IRQ: irq <= |(edge_cap & mask), registered, so it is 1 cycle after edge/mask change.
//   irq stays high until the offending bit is cleared or masked.
//  Counter never wraps; it is bounded by DEB_CYCLES-1.
//  Keys are fully independent; simultaneous events on several keys each capture.
//  Reset mid-count aborts all state to reset values; no edge is captured on reset release.
// STRUCTURE
//  Package fpro_key_pkg: register address localparams (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2,
//   ADDR_RAW=3), the debounce state encoding (ST_STABLE, ST_COUNT) and the key reset level (1).
//  Sub-module fpro_key_debounce: one key's synchroniser, counter and FSM.
//   Outputs deb_level and press_pulse. Instantiated N_KEYS times via generate.
//  Top level holds the mask and edge registers, the IRQ logic and the read mux.
// TESTING  (bench uses DEB_CYCLES=4, N_KEYS=2)
//  1 Reset, idle in_port=11 -> readdata=0 and irq=0 during reset.
//    Read addr0 -> 0x3; read addr2 -> 0x0.
//  2 Bounce: key0 low 3 clocks, then high -> DATA stays 0x3, EDGE_CAP 0x0, irq 0.
//  3 Hold key0 low -> DATA=0x2 exactly 6 clocks after the pin change, EDGE_CAP=0x1,
//    irq stays 0 (mask 0). Write mask=0x1 -> irq=1 one clock after the write.
//  4 Write addr2=0x1 -> EDGE_CAP=0, irq drops next clock.
//    Repeat with the W1C landing on the capture cycle -> bit remains 1.
//  5 Both keys pressed on the same clock -> EDGE_CAP=0x3.
//    Write 0x2 -> EDGE_CAP=0x1. Release both -> no new capture.
//  6 Assert reset_n mid-count (cnt=2) on key1 -> all registers at reset values.
//    After release with key1 still low -> DATA=0x1 after 6 clocks, and EDGE_CAP bit1 sets.

Source files
------------

// File: rtl/fpro_key_pkg.sv
// rtl/fpro_key_pkg.sv - shared register map, debounce state encoding and key reset level
// Purpose : constants and types shared by the key controller and its per-key debouncer.
// Contents: ADDR_* register indices, deb_state_e FSM encoding, KEY_RESET_LEVEL.
package fpro_key_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  // Keys are active-low, so the idle/released level is 1.
  localparam logic KEY_RESET_LEVEL = 1'b1;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/fpro_key_debounce.sv
// rtl/fpro_key_debounce.sv - one key: 2-FF synchroniser, debounce counter and FSM
// Purpose : accepts a new synchronised level only after it has held for DEB_CYCLES clocks.
// Ports   : clk, reset_n (async, active-low), pin (raw async key),
//           sync_level (synchroniser output), deb_level (accepted level),
//           press_pulse (1 on the edge where deb_level goes 1->0, combinational).
module fpro_key_debounce
  import fpro_key_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic sync_level,
  output logic deb_level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  deb_state_e       state;
  deb_state_e       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             deb;
  logic             deb_nx;

  // Synchroniser resets to the released level, independent of the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= KEY_RESET_LEVEL;
      sync_2 <= KEY_RESET_LEVEL;
    end else begin
      sync_1 <= pin;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      deb   <= KEY_RESET_LEVEL;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      deb   <= deb_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    deb_nx      = deb;
    press_pulse = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync_2 != deb) begin
          state_nx = ST_COUNT;
          cnt_nx   = CNT_W'(1);
        end else begin
          cnt_nx = '0;
        end
      end
      ST_COUNT: begin
        // Bounce rejection takes priority over acceptance on the final count.
        if (sync_2 == deb) begin
          state_nx = ST_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx    = ST_STABLE;
          cnt_nx      = '0;
          deb_nx      = sync_2;
          // sync_2 differs from deb here, so a press is exactly deb currently high.
          press_pulse = deb;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign sync_level = sync_2;
  assign deb_level  = deb;

endmodule

// File: rtl/fpro_key_ctrl.sv
// rtl/fpro_key_ctrl.sv - Avalon-MM push-key controller with debounce, press capture and IRQ
// Purpose : register front end over N_KEYS debouncers: DATA, IRQ_MASK, EDGE_CAP (W1C), RAW.
// Ports   : clk, reset_n (async, active-low), chipselect, address[1:0], write_n,
//           writedata[31:0], readdata[31:0] (registered), in_port[N_KEYS-1:0], irq (level).
module fpro_key_ctrl
  import fpro_key_pkg::*;
#(
  parameter int N_KEYS     = 2,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [1:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [N_KEYS-1:0] in_port,
  output logic              irq
);

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] deb;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] mask;
  logic [N_KEYS-1:0] edge_cap;
  logic [N_KEYS-1:0] w1c;
  logic [31:0]       rd_nx;
  logic              wr_en;
  logic              unused_wdata;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    fpro_key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_debounce (
      .clk         (clk),
      .reset_n     (reset_n),
      .pin         (in_port[g]),
      .sync_level  (raw[g]),
      .deb_level   (deb[g]),
      .press_pulse (press[g])
    );
  end

  assign wr_en        = chipselect & ~write_n;
  assign w1c          = (wr_en && address == ADDR_EDGE) ? writedata[N_KEYS-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask     <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      if (wr_en && address == ADDR_MASK) begin
        mask <= writedata[N_KEYS-1:0];
      end
      // OR-ing the press in after the clear makes a same-cycle capture win over W1C.
      edge_cap <= (edge_cap & ~w1c) | press;
      irq      <= |(edge_cap & mask);
      readdata <= rd_nx;
    end
  end

  always_comb begin
    rd_nx = '0;
    case (address)
      ADDR_DATA: rd_nx[N_KEYS-1:0] = deb;
      ADDR_MASK: rd_nx[N_KEYS-1:0] = mask;
      ADDR_EDGE: rd_nx[N_KEYS-1:0] = edge_cap;
      ADDR_RAW:  rd_nx[N_KEYS-1:0] = raw;
      default:   rd_nx = '0;
    endcase
  end

endmodule

// File: tb/tb_fpro_key_ctrl.sv
// tb/tb_fpro_key_ctrl.sv - directed self-checking bench for fpro_key_ctrl (DEB_CYCLES=4, N_KEYS=2)
module tb_fpro_key_ctrl;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  fpro_key_ctrl #(
    .N_KEYS     (2),
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  logic [31:0] rd;
  logic        stray;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 2'd0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 2'b11;

    // 1 reset and idle
    tick(2);
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(4);
    bus_read(2'd0, rd); check_eq("idle_data", rd, 32'h3);
    bus_read(2'd2, rd); check_eq("idle_edge", rd, 32'h0);
    bus_read(2'd3, rd); check_eq("idle_raw", rd, 32'h3);

    // 2 bounce: key0 low for 3 sampled clocks only
    in_port = 2'b10;
    tick(3);
    in_port = 2'b11;
    address = 2'd0;
    stray   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (readdata != 32'h3 || irq) stray = 1'b1;
    end
    check_eq("bounce_stable", {31'b0, stray}, 32'h0);
    bus_read(2'd2, rd); check_eq("bounce_edge", rd, 32'h0);

    // 3 clean press of key0: deb changes on the 6th edge, readdata shows it one later
    address = 2'd0;
    in_port = 2'b10;
    tick(6); check_eq("press_data_6", readdata, 32'h3);
    tick();  check_eq("press_data_7", readdata, 32'h2);
    bus_read(2'd2, rd); check_eq("press_edge", rd, 32'h1);
    check_eq("press_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd1, 32'h1);
    check_eq("mask_irq_same", {31'b0, irq}, 32'h0);
    tick();
    check_eq("mask_irq_next", {31'b0, irq}, 32'h1);
    bus_read(2'd1, rd); check_eq("mask_read", rd, 32'h1);

    // 4 W1C clears the capture, irq drops one clock later
    bus_write(2'd2, 32'h1);
    check_eq("w1c_irq_same", {31'b0, irq}, 32'h1);
    bus_read(2'd2, rd); check_eq("w1c_edge", rd, 32'h0);
    check_eq("w1c_irq_next", {31'b0, irq}, 32'h0);
    // release captures nothing
    in_port = 2'b11;
    tick(8);
    bus_read(2'd2, rd); check_eq("release_edge", rd, 32'h0);
    bus_read(2'd0, rd); check_eq("release_data", rd, 32'h3);
    // W1C lands on the capture edge: set wins
    in_port = 2'b10;
    tick(5);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); check_eq("set_wins_edge", rd, 32'h1);
    check_eq("set_wins_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h1);

    // 5 both keys pressed together
    in_port = 2'b11;
    tick(8);
    in_port = 2'b00;
    tick(8);
    bus_read(2'd2, rd); check_eq("both_edge", rd, 32'h3);
    bus_read(2'd0, rd); check_eq("both_data", rd, 32'h0);
    bus_write(2'd2, 32'h2);
    bus_read(2'd2, rd); check_eq("w1c_bit1", rd, 32'h1);
    in_port = 2'b11;
    tick(8);
    bus_read(2'd2, rd); check_eq("both_release_edge", rd, 32'h1);
    bus_read(2'd0, rd); check_eq("both_release_data", rd, 32'h3);
    check_eq("both_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd1, 32'h0);
    tick();
    check_eq("unmask_irq", {31'b0, irq}, 32'h0);
    bus_write(2'd0, 32'h0);
    bus_write(2'd3, 32'h0);
    bus_read(2'd0, rd); check_eq("ro_data_write", rd, 32'h3);
    bus_write(2'd1, 32'h1);
    tick();
    check_eq("remask_irq", {31'b0, irq}, 32'h1);

    // 6 reset mid-count on key1 (cnt=2 after the 4th edge)
    address = 2'd2;
    in_port = 2'b01;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_readdata", readdata, 32'h0);
    check_eq("midrst_irq", {31'b0, irq}, 32'h0);
    tick(2);
    address = 2'd0;
    reset_n = 1'b1;
    tick(6); check_eq("post_rst_data_6", readdata, 32'h3);
    tick();  check_eq("post_rst_data_7", readdata, 32'h1);
    bus_read(2'd2, rd); check_eq("post_rst_edge", rd, 32'h2);
    bus_read(2'd1, rd); check_eq("post_rst_mask", rd, 32'h0);
    check_eq("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
